// File: rtl/scanline_bank_splitter_if.sv
// CPU register bus of the scanline bank splitter: write/read strobes, address,
// write data, combinational readback and the register-window select.
interface scanline_bank_splitter_if;
  logic        wr;
  logic        rd;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        sel;

  modport master (output wr, rd, addr, data_in, input data_out, sel);
  modport slave  (input wr, rd, addr, data_in, output data_out, sel);
endinterface

// File: rtl/scanline_bank_splitter.sv
// Raster-split CHR banker. Synchronises raw PPU read strobes, counts scanlines
// from nametable-fetch signatures and tiles from A13 transitions, swaps the CHR
// bank from a CPU-programmed (scanline, bank) table and raises a line IRQ.
module scanline_bank_splitter #(
  parameter int          NUM_SPLITS  = 4,
  parameter int          BANK_BITS   = 2,
  parameter logic [15:0] REG_BASE    = 16'h5010,
  parameter int          SYNC_STAGES = 2,
  parameter int          MATCH_COUNT = 3,
  parameter int          SWITCH_TILE = 40
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ppu_rd_n,
  input  logic [13:0]           ppu_addr,
  input  logic                  frame_start,
  scanline_bank_splitter_if.slave cpu,
  output logic [BANK_BITS-1:0]  chr_bank,
  output logic                  irq
);

  localparam int IDX_BITS   = (NUM_SPLITS > 1) ? $clog2(NUM_SPLITS) : 1;
  localparam int MATCH_BITS = (MATCH_COUNT > 0) ? $clog2(MATCH_COUNT + 1) : 1;

  typedef enum logic [2:0] {
    R_CTRL, R_IDX, R_LINE, R_BANK, R_BASEBANK, R_IRQLINE, R_STATUS, R_SCAN
  } reg_e;

  // Only A13:12 steer the logic; the low address bits are never looked at.
  logic [11:0] unused_addr;
  logic        unused_rd;
  assign unused_addr = ppu_addr[11:0];
  assign unused_rd   = cpu.rd;

  logic [SYNC_STAGES-1:0] rd_sync;
  logic [1:0]             a_sync [SYNC_STAGES];
  logic                   rd_prev;

  // Synchroniser chains for /RD and A13:12, plus the edge-detect history bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sync <= '1;
      rd_prev <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) a_sync[i] <= '0;
    end else begin
      rd_sync   <= {rd_sync[SYNC_STAGES-2:0], ppu_rd_n};
      rd_prev   <= rd_sync[SYNC_STAGES-1];
      a_sync[0] <= ppu_addr[13:12];
      for (int i = 1; i < SYNC_STAGES; i++) a_sync[i] <= a_sync[i-1];
    end
  end

  logic       fetch, fetch_ok;
  logic [1:0] f_addr;
  assign fetch    = rd_prev & ~rd_sync[SYNC_STAGES-1];
  assign f_addr   = a_sync[SYNC_STAGES-1];
  assign fetch_ok = fetch & ~frame_start;   // frame_start swallows a coincident fetch

  // CPU register decode; subtraction keeps the window correct even near 16'hFFFF.
  logic [15:0] offset;
  reg_e        reg_off;
  logic        wr_en;
  assign offset  = cpu.addr - REG_BASE;
  assign cpu.sel = (offset[15:3] == 13'd0);
  assign reg_off = reg_e'(offset[2:0]);
  assign wr_en   = cpu.wr & cpu.sel;

  logic                 split_en, irq_en, in_frame, irq_pending, last_a13;
  logic [IDX_BITS-1:0]  idx;
  logic [7:0]           line_tab  [NUM_SPLITS];
  logic [BANK_BITS-1:0] bank_tab  [NUM_SPLITS];
  logic                 valid_tab [NUM_SPLITS];
  logic [BANK_BITS-1:0] base_bank;
  logic [7:0]           irq_line, scanline_cnt, scan_next;
  logic [5:0]           tile_cnt;
  logic [MATCH_BITS-1:0] match_cnt;
  logic [8:0]           data_ext;

  assign data_ext = {1'b0, cpu.data_in};

  logic line_evt, split_try, irq_set;
  assign line_evt  = fetch_ok && (f_addr == 2'b10) && (match_cnt == MATCH_BITS'(MATCH_COUNT));
  assign scan_next = (scanline_cnt == 8'hFF) ? 8'hFF : scanline_cnt + 8'd1;
  assign split_try = fetch_ok && !last_a13 && f_addr[1] && (tile_cnt == 6'(SWITCH_TILE)) && split_en;
  assign irq_set   = line_evt && irq_en && (scan_next == irq_line);

  // Lowest-index valid entry whose line matches the current scanline.
  logic                 hit;
  logic [BANK_BITS-1:0] hit_bank;
  // NOTE: every combinational output is defaulted first so no path can infer a latch.
  always_comb begin
    hit      = 1'b0;
    hit_bank = '0;
    for (int i = NUM_SPLITS - 1; i >= 0; i--) begin
      if (valid_tab[i] && (line_tab[i] == scanline_cnt)) begin
        hit      = 1'b1;
        hit_bank = bank_tab[i];
      end
    end
  end

  // CPU-writable configuration registers and the split table.
  // NOTE: the table is a handful of flops, so it is reset like any register (valid bits must start clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      split_en  <= 1'b0;
      irq_en    <= 1'b0;
      idx       <= '0;
      base_bank <= '0;
      irq_line  <= '0;
      for (int i = 0; i < NUM_SPLITS; i++) begin
        line_tab[i]  <= '0;
        bank_tab[i]  <= '0;
        valid_tab[i] <= 1'b0;
      end
    end else if (wr_en) begin
      case (reg_off)
        R_CTRL: begin
          split_en <= cpu.data_in[0];
          irq_en   <= cpu.data_in[1];
        end
        R_IDX:      if (int'(cpu.data_in) < NUM_SPLITS) idx <= IDX_BITS'(cpu.data_in);
        R_LINE:     line_tab[idx] <= cpu.data_in;
        R_BANK: begin
          valid_tab[idx] <= cpu.data_in[0];
          bank_tab[idx]  <= data_ext[BANK_BITS:1];
        end
        R_BASEBANK: base_bank <= cpu.data_in[BANK_BITS-1:0];
        R_IRQLINE:  irq_line  <= cpu.data_in;
        default: ;
      endcase
    end
  end

  // Scanline / tile / match counters driven by qualified fetches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scanline_cnt <= '0;
      tile_cnt     <= '0;
      match_cnt    <= '0;
      last_a13     <= 1'b0;
      in_frame     <= 1'b0;
    end else if (frame_start) begin
      scanline_cnt <= '0;
      tile_cnt     <= '0;
      match_cnt    <= '0;
      in_frame     <= 1'b1;
    end else if (fetch) begin
      if (f_addr == 2'b10) begin
        if (line_evt) begin
          scanline_cnt <= scan_next;
          tile_cnt     <= '0;
        end else begin
          match_cnt <= match_cnt + MATCH_BITS'(1);
        end
      end else begin
        match_cnt <= '0;
      end
      if (last_a13 && !f_addr[1] && (tile_cnt != 6'd63)) tile_cnt <= tile_cnt + 6'd1;
      last_a13 <= f_addr[1];
    end
  end

  // CHR bank: base bank at frame start, table bank at the switch point.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                chr_bank <= '0;
    else if (frame_start)        chr_bank <= base_bank;
    else if (split_try && hit)   chr_bank <= hit_bank;
  end

  // Scanline-compare IRQ; a set on the same cycle as a STATUS write wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             irq_pending <= 1'b0;
    else if (irq_set)                         irq_pending <= 1'b1;
    else if (wr_en && (reg_off == R_STATUS))  irq_pending <= 1'b0;
  end

  assign irq = irq_pending;

  // Register readback, purely combinational from the CPU address.
  logic [8:0] bank_rd;
  logic [7:0] rd_data;
  assign bank_rd = 9'({bank_tab[idx], valid_tab[idx]});
  always_comb begin
    rd_data = '0;
    case (reg_off)
      R_CTRL:     rd_data = {6'b0, irq_en, split_en};
      R_IDX:      rd_data = 8'(idx);
      R_LINE:     rd_data = line_tab[idx];
      R_BANK:     rd_data = bank_rd[7:0];
      R_BASEBANK: rd_data = 8'(base_bank);
      R_IRQLINE:  rd_data = irq_line;
      R_STATUS:   rd_data = {irq_pending, 6'b0, in_frame};
      R_SCAN:     rd_data = scanline_cnt;
      default:    rd_data = '0;
    endcase
  end

  assign cpu.data_out = cpu.sel ? rd_data : 8'h00;

endmodule

// File: tb/tb_scanline_bank_splitter.sv
// Directed bench for scanline_bank_splitter: register map, scanline detection,
// split switching and priority, IRQ set/clear, frame restart and reset.
module tb_scanline_bank_splitter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ppu_rd_n = 1'b1;
  logic [13:0] ppu_addr = '0;
  logic        frame_start = 1'b0;
  logic [1:0]  chr_bank;
  logic        irq;
  logic        irq_pre;
  logic [7:0]  rd;
  int          checks = 0;
  int          failures = 0;

  scanline_bank_splitter_if cpu_bus ();

  scanline_bank_splitter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ppu_rd_n   (ppu_rd_n),
    .ppu_addr   (ppu_addr),
    .frame_start(frame_start),
    .cpu        (cpu_bus.slave),
    .chr_bank   (chr_bank),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic wr_reg(input logic [2:0] off, input logic [7:0] d);
    cpu_bus.addr    = 16'h5010 + {13'd0, off};
    cpu_bus.data_in = d;
    cpu_bus.wr      = 1'b1;
    @(posedge clk); #1;
    cpu_bus.wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] off, output logic [7:0] d);
    cpu_bus.addr = 16'h5010 + {13'd0, off};
    cpu_bus.rd   = 1'b1;
    #1 d = cpu_bus.data_out;
    cpu_bus.rd = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // One PPU fetch aligned to clk. co=1 adds a CPU write and co=2 a frame_start
  // on the exact cycle the fetch is processed; irq_pre samples irq just before.
  task automatic fetch(input logic [13:0] a, input int co, input logic [2:0] off, input logic [7:0] d);
    ppu_addr = a;
    ppu_rd_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    irq_pre = irq;
    if (co == 1) begin
      cpu_bus.addr = 16'h5010 + {13'd0, off};
      cpu_bus.data_in = d;
      cpu_bus.wr = 1'b1;
    end
    if (co == 2) frame_start = 1'b1;
    @(posedge clk); #1;
    cpu_bus.wr  = 1'b0;
    frame_start = 1'b0;
    ppu_rd_n    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic f(input logic [13:0] a);
    fetch(a, 0, 3'd0, 8'd0);
  endtask

  // Fetch with /RD edges at arbitrary phase relative to clk.
  task automatic fetch_async(input logic [13:0] a);
    #($urandom_range(0, 7));
    ppu_addr = a;
    ppu_rd_n = 1'b0;
    repeat (4) @(posedge clk);
    #($urandom_range(1, 8));
    ppu_rd_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic goto_line(input int n);
    for (int i = 0; i < n + 3; i++) f(14'h2000);
  endtask

  task automatic tiles(input int n);
    f(14'h0000);
    for (int i = 0; i < n - 1; i++) begin
      f(14'h3000);
      f(14'h0000);
    end
  endtask

  task automatic test_reset();
    checks++; if (chr_bank !== 2'd0) begin failures++; $display("FAIL reset_chr got=%0d exp=0", chr_bank); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", irq); end
    rd_reg(3'd7, rd);
    checks++; if (rd !== 8'd0) begin failures++; $display("FAIL reset_scan got=%0h exp=0", rd); end
    rd_reg(3'd6, rd);
    checks++; if (rd !== 8'd0) begin failures++; $display("FAIL reset_status got=%0h exp=0", rd); end
    rd_reg(3'd3, rd);
    checks++; if (rd !== 8'd0) begin failures++; $display("FAIL reset_bank got=%0h exp=0", rd); end
    cpu_bus.addr = 16'h500F; #1;
    checks++; if (cpu_bus.sel !== 1'b0) begin failures++; $display("FAIL sel_below got=%0b exp=0", cpu_bus.sel); end
    cpu_bus.addr = 16'h5017; #1;
    checks++; if (cpu_bus.sel !== 1'b1) begin failures++; $display("FAIL sel_top got=%0b exp=1", cpu_bus.sel); end
    cpu_bus.addr = 16'h5018; #1;
    checks++; if (cpu_bus.sel !== 1'b0) begin failures++; $display("FAIL sel_above got=%0b exp=0", cpu_bus.sel); end
  endtask

  task automatic test_regs();
    wr_reg(3'd0, 8'hFF);
    rd_reg(3'd0, rd);
    checks++; if (rd !== 8'h03) begin failures++; $display("FAIL ctrl_rd got=%0h exp=03", rd); end
    wr_reg(3'd1, 8'd2);
    wr_reg(3'd1, 8'd5);
    rd_reg(3'd1, rd);
    checks++; if (rd !== 8'd2) begin failures++; $display("FAIL idx_ignore got=%0h exp=02", rd); end
    wr_reg(3'd2, 8'h5A);
    wr_reg(3'd3, 8'hFF);
    rd_reg(3'd2, rd);
    checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL line_rd got=%0h exp=5a", rd); end
    rd_reg(3'd3, rd);
    checks++; if (rd !== 8'h07) begin failures++; $display("FAIL bank_rd got=%0h exp=07", rd); end
    wr_reg(3'd5, 8'hC3);
    rd_reg(3'd5, rd);
    checks++; if (rd !== 8'hC3) begin failures++; $display("FAIL irqline_rd got=%0h exp=c3", rd); end
    wr_reg(3'd7, 8'h44);
    rd_reg(3'd7, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL scan_wr_ignored got=%0h exp=00", rd); end
    wr_reg(3'd3, 8'h00);
    wr_reg(3'd0, 8'h00);
  endtask

  task automatic test_scanline();
    pulse_frame();
    rd_reg(3'd6, rd);
    checks++; if (rd !== 8'h01) begin failures++; $display("FAIL in_frame got=%0h exp=01", rd); end
    for (int i = 0; i < 3; i++) f(14'h2000);
    rd_reg(3'd7, rd);
    checks++; if (rd !== 8'd0) begin failures++; $display("FAIL scan_three got=%0d exp=0", rd); end
    f(14'h2001);
    rd_reg(3'd7, rd);
    checks++; if (rd !== 8'd1) begin failures++; $display("FAIL scan_first got=%0d exp=1", rd); end
    pulse_frame();
    f(14'h2000); f(14'h2000); f(14'h0000); f(14'h2000); f(14'h2000);
    rd_reg(3'd7, rd);
    checks++; if (rd !== 8'd0) begin failures++; $display("FAIL scan_interposed got=%0d exp=0", rd); end
    pulse_frame();
    goto_line(255);
    rd_reg(3'd7, rd);
    checks++; if (rd !== 8'd255) begin failures++; $display("FAIL scan_255 got=%0d exp=255", rd); end
    f(14'h2000);
    rd_reg(3'd7, rd);
    checks++; if (rd !== 8'd255) begin failures++; $display("FAIL scan_saturate got=%0d exp=255", rd); end
  endtask

  task automatic test_split();
    wr_reg(3'd1, 8'd0);
    wr_reg(3'd2, 8'd64);
    wr_reg(3'd3, 8'h03);
    wr_reg(3'd4, 8'd0);
    wr_reg(3'd0, 8'h01);
    pulse_frame();
    goto_line(64);
    rd_reg(3'd7, rd);
    checks++; if (rd !== 8'd64) begin failures++; $display("FAIL split_line got=%0d exp=64", rd); end
    tiles(39);
    f(14'h3000);
    checks++; if (chr_bank !== 2'd0) begin failures++; $display("FAIL split_tile39 got=%0d exp=0", chr_bank); end
    pulse_frame();
    goto_line(64);
    tiles(40);
    f(14'h3000);
    checks++; if (chr_bank !== 2'd1) begin failures++; $display("FAIL split_tile40 got=%0d exp=1", chr_bank); end
  endtask

  task automatic test_priority();
    wr_reg(3'd1, 8'd0); wr_reg(3'd2, 8'd10); wr_reg(3'd3, 8'h07);
    wr_reg(3'd1, 8'd2); wr_reg(3'd2, 8'd10); wr_reg(3'd3, 8'h03);
    pulse_frame();
    goto_line(10);
    tiles(40);
    f(14'h3000);
    checks++; if (chr_bank !== 2'd3) begin failures++; $display("FAIL prio_lowest got=%0d exp=3", chr_bank); end
    wr_reg(3'd1, 8'd0); wr_reg(3'd3, 8'h06);
    pulse_frame();
    goto_line(10);
    tiles(40);
    f(14'h3000);
    checks++; if (chr_bank !== 2'd1) begin failures++; $display("FAIL prio_invalid got=%0d exp=1", chr_bank); end
  endtask

  task automatic test_irq();
    wr_reg(3'd0, 8'h02);
    wr_reg(3'd5, 8'd5);
    pulse_frame();
    goto_line(4);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_line4 got=%0b exp=0", irq); end
    f(14'h2000);
    checks++; if (irq_pre !== 1'b0) begin failures++; $display("FAIL irq_before got=%0b exp=0", irq_pre); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%0b exp=1", irq); end
    rd_reg(3'd6, rd);
    checks++; if (rd !== 8'h81) begin failures++; $display("FAIL irq_status got=%0h exp=81", rd); end
    wr_reg(3'd6, 8'h00);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%0b exp=0", irq); end
    pulse_frame();
    goto_line(4);
    fetch(14'h2000, 1, 3'd6, 8'h00);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins got=%0b exp=1", irq); end
    wr_reg(3'd0, 8'h00);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_en_off_keeps got=%0b exp=1", irq); end
    wr_reg(3'd6, 8'h00);
    pulse_frame();
    goto_line(5);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_disabled got=%0b exp=0", irq); end
  endtask

  task automatic test_frame();
    wr_reg(3'd4, 8'd2);
    pulse_frame();
    wr_reg(3'd4, 8'd2);
    goto_line(3);
    wr_reg(3'd4, 8'd3);
    fetch(14'h2000, 2, 3'd0, 8'd0);
    checks++; if (chr_bank !== 2'd3) begin failures++; $display("FAIL frame_base got=%0d exp=3", chr_bank); end
    rd_reg(3'd7, rd);
    checks++; if (rd !== 8'd0) begin failures++; $display("FAIL frame_scan got=%0d exp=0", rd); end
    for (int i = 0; i < 3; i++) f(14'h2000);
    rd_reg(3'd7, rd);
    checks++; if (rd !== 8'd0) begin failures++; $display("FAIL frame_dropped got=%0d exp=0", rd); end
    f(14'h2000);
    rd_reg(3'd7, rd);
    checks++; if (rd !== 8'd1) begin failures++; $display("FAIL frame_first got=%0d exp=1", rd); end
    pulse_frame();
    fetch_async(14'h2000); fetch_async(14'h2000); fetch_async(14'h0000);
    for (int i = 0; i < 6; i++) fetch_async(14'h2000);
    rd_reg(3'd7, rd);
    checks++; if (rd !== 8'd3) begin failures++; $display("FAIL async_scan got=%0d exp=3", rd); end
  endtask

  task automatic test_reset_mid();
    wr_reg(3'd4, 8'd2);
    wr_reg(3'd0, 8'h02);
    wr_reg(3'd5, 8'd1);
    pulse_frame();
    goto_line(1);
    checks++; if (chr_bank !== 2'd2 || irq !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d/%0b exp=2/1", chr_bank, irq); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (chr_bank !== 2'd0) begin failures++; $display("FAIL mid_chr got=%0d exp=0", chr_bank); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_irq got=%0b exp=0", irq); end
    @(posedge clk); #1 reset_n = 1'b1;
    rd_reg(3'd7, rd);
    checks++; if (rd !== 8'd0) begin failures++; $display("FAIL mid_scan got=%0d exp=0", rd); end
    rd_reg(3'd4, rd);
    checks++; if (rd !== 8'd0) begin failures++; $display("FAIL mid_basebank got=%0d exp=0", rd); end
    rd_reg(3'd6, rd);
    checks++; if (rd !== 8'd0) begin failures++; $display("FAIL mid_status got=%0h exp=0", rd); end
  endtask

  initial begin
    cpu_bus.wr      = 1'b0;
    cpu_bus.rd      = 1'b0;
    cpu_bus.addr    = 16'h0000;
    cpu_bus.data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset();
    test_regs();
    test_scanline();
    test_split();
    test_priority();
    test_irq();
    test_frame();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
